// File: rtl/elink_2bit_tx_serializer.sv
// ---------------------------------------------------------------------------
// elink_2bit_tx_serializer
//
// Transmit framer for a 2-bit DDR e-link. Pre-encoded 8b10b symbols are
// queued in a small FIFO and sent as five 2-bit pairs, one pair per clk.
// When there is no data, or transmission is disabled, K28.5 commas are
// inserted with alternating running disparity so the far end keeps word lock.
//
// Ports
//   clk           elink word clock, one pair per rising edge
//   reset         synchronous, active-high
//   enable        1: FIFO may be popped at a symbol boundary; 0: idles only
//   din           10-bit 8b10b symbol, bit 9 goes out first
//   din_valid     din carries a symbol this cycle
//   din_ready     FIFO has room (combinational from registered level)
//   tx_elink2bit  pair for the DDR output register; [0] = D1 (first bit out)
//   fifo_level    number of symbols currently queued
//   sym_strobe    1-cycle pulse while the first pair of a symbol is driven
//   sym_is_idle   the symbol being shifted out is an inserted comma
//
// FIFO_DEPTH must be a power of two >= 2 so the pointers wrap naturally.
// ---------------------------------------------------------------------------
module elink_2bit_tx_serializer #(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter logic [9:0]  IDLE_NEG   = 10'b0011111010,
    parameter logic [9:0]  IDLE_POS   = 10'b1100000101
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              enable,
    input  logic [9:0]                        din,
    input  logic                              din_valid,
    output logic                              din_ready,
    output logic [1:0]                        tx_elink2bit,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_level,
    output logic                              sym_strobe,
    output logic                              sym_is_idle
);

    localparam int unsigned       PTR_W    = $clog2(FIFO_DEPTH);
    localparam int unsigned       LVL_W    = $clog2(FIFO_DEPTH + 1);
    localparam logic [LVL_W-1:0]  FULL_LVL = LVL_W'(FIFO_DEPTH);

    // Phases 0..3 shift out pairs 2..5; PH_LOAD picks the next symbol and
    // drives its first pair, so a symbol occupies exactly five cycles.
    typedef enum logic [2:0] {
        PH_S0   = 3'd0,
        PH_S1   = 3'd1,
        PH_S2   = 3'd2,
        PH_S3   = 3'd3,
        PH_LOAD = 3'd4
    } phase_e;

    // ---------------------------------------------------------------------
    // State
    // ---------------------------------------------------------------------
    logic [9:0]       mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0] level_q,  level_d;
    phase_e           phase_q,  phase_d;
    logic [9:0]       sreg_q,   sreg_d;
    logic             pol_q,    pol_d;     // 0: next idle is IDLE_NEG
    logic [1:0]       tx_q,     tx_d;
    logic             strobe_q, strobe_d;
    logic             idle_q,   idle_d;

    logic             push;
    logic             pop;
    logic [9:0]       word;

    // No bypass: a full FIFO refuses input even when a pop is happening.
    assign din_ready = (level_q != FULL_LVL);
    assign push      = din_valid && din_ready;
    assign pop       = (phase_q == PH_LOAD) && enable && (level_q != '0);

    // Symbol chosen at the load boundary: FIFO head, else current comma.
    assign word = pop ? mem_q[rd_ptr_q] : (pol_q ? IDLE_POS : IDLE_NEG);

    // ---------------------------------------------------------------------
    // Next-state logic
    // ---------------------------------------------------------------------
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        phase_d  = phase_q;
        sreg_d   = sreg_q;
        pol_d    = pol_q;
        tx_d     = tx_q;
        strobe_d = 1'b0;
        idle_d   = idle_q;

        if (push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end

        unique case ({push, pop})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
        endcase

        // Pair ordering: the earlier bit of each pair lands in [0] (D1).
        unique case (phase_q)
            PH_LOAD: begin
                tx_d     = {word[8], word[9]};
                sreg_d   = {word[7:0], 2'b00};
                strobe_d = 1'b1;
                idle_d   = !pop;
                phase_d  = PH_S0;
                // Disparity only alternates across inserted commas; data
                // symbols carry whatever disparity upstream chose.
                if (!pop) begin
                    pol_d = !pol_q;
                end
            end
            PH_S0, PH_S1, PH_S2, PH_S3: begin
                tx_d    = {sreg_q[8], sreg_q[9]};
                sreg_d  = {sreg_q[7:0], 2'b00};
                phase_d = phase_e'(phase_q + 3'd1);
            end
            default: begin
                // Unreachable encodings recover to a load boundary.
                phase_d = PH_LOAD;
            end
        endcase
    end

    // ---------------------------------------------------------------------
    // Registers
    // ---------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            phase_q  <= PH_LOAD;
            sreg_q   <= '0;
            pol_q    <= 1'b0;
            tx_q     <= 2'b00;
            strobe_q <= 1'b0;
            idle_q   <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            phase_q  <= phase_d;
            sreg_q   <= sreg_d;
            pol_q    <= pol_d;
            tx_q     <= tx_d;
            strobe_q <= strobe_d;
            idle_q   <= idle_d;
        end
    end

    // Storage needs no reset; pointers and level define what is valid.
    always_ff @(posedge clk) begin
        if (push && !reset) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

    assign tx_elink2bit = tx_q;
    assign fifo_level   = level_q;
    assign sym_strobe   = strobe_q;
    assign sym_is_idle  = idle_q;

endmodule
